rom_burst_arbiter: RTL and testbench
====================================

// Module: rom_burst_arbiter
// PURPOSE
//  Shares one combinational 16x8 lookup ROM between NREQ requesters. Each requester asks for a
//  burst of consecutive ROM words. The block arbitrates between requesters, drives the ROM
//  address, and streams the words out through a registered valid/ready port tagged with the
//  requester id. It sits between the ROM and its client engines.
// PARAMETERS
//  NREQ = 2 : number of requesters (2..4)
//  AW   = 4 : ROM address width
//  DW   = 8 : ROM data width
//  LW   = 4 : burst length field width; encoding is word count minus 1
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  req         in   NREQ     request level per requester
//  start_addr  in   NREQ*AW  first word address; requester i uses bits [i*AW +: AW]
//  burst_len   in   NREQ*LW  words-1 per requester (0 -> 1 word, 15 -> 16 words)
//  gnt         out  NREQ     one-hot, one-cycle grant pulse
//  rom_addr    out  AW       registered address to the ROM
//  rom_data    in   DW       combinational ROM read data for rom_addr
//  out_data    out  DW       registered burst word
//  out_valid   out  1        out_data valid
//  out_ready   in   1        consumer accepts when out_valid && out_ready
//  out_id      out  2        index of the owning requester
//  out_last    out  1        high with the final word of a burst
//  busy        out  1        high whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE. gnt=0, rom_addr=0, out_data=0, out_valid=0, out_id=0, out_last=0.
//    Internal remaining count and round-robin pointer are 0. Async assert, sync deassert.
//    Reset mid-burst abandons the burst; no further words are emitted.
//  - FSM states:
//    - IDLE: if any req bit is high at an edge, pick a winner. Registered results at that edge:
//      gnt[w]=1, out_id=w, rom_addr=start_addr[w], remaining=burst_len[w], state=STREAM.
//    - STREAM: load = !out_valid || out_ready. On load: out_data<=rom_data, out_valid<=1,
//      out_last<=(remaining==0), rom_addr<=rom_addr+1. If remaining==0, go to DRAIN;
//      otherwise remaining<=remaining-1.
//    - DRAIN: when out_ready, clear out_valid and out_last, then go to IDLE.
//  - gnt lasts exactly one cycle. The first word is valid one cycle after the gnt cycle.
//    With out_ready held high, the block delivers 1 word/cycle.
//  - Occupancy per burst: 1 grant cycle + N stream cycles + 1 drain cycle. The next grant can
//    come at the edge after the DRAIN handshake.
//  - rom_addr wraps modulo 2^AW (0xF+1 -> 0x0). Wrap is not an error.
//  - req, start_addr and burst_len are sampled only in IDLE. Dropping req mid-burst does not
//    shorten the burst. Changing start_addr mid-burst has no effect.
//  - Backpressure: while out_valid && !out_ready, out_data/out_last/out_id and rom_addr hold
//    their values.
//  - Simultaneous requests are resolved by the arbitration rule (see CONFIGURATION). A
//    requester that keeps req high after its burst re-enters arbitration.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//    - Round-robin. Search starts at (last_winner+1) mod NREQ.
//    - Pointer updates on every grant; after reset the search starts at index 0.
//    - No requester waits more than NREQ-1 bursts.
//  ARB_ROUND_ROBIN_EN undefined:
//    - Fixed priority; the lowest index wins. No pointer register is built.
// TESTING  (ROM model: rom_data = {rom_addr, ~rom_addr})
//  1. req=01, start=0x2, len=2, ready=1
//     -> gnt=01 for 1 cycle; words 0x2D,0x3C,0x4B on consecutive cycles; out_last on 0x4B;
//        out_id=0; busy drops after DRAIN.
//  2. req=10, start=0xE, len=3
//     -> words 0xE1,0xF0,0x0F,0x1E (address wraps); out_id=1.
//  3. start=0x5, len=1, out_ready=0 for 3 cycles after the first valid
//     -> out_data holds 0x5A, rom_addr holds; then 0x5A,0x69 delivered in order; no loss or
//        duplication.
//  4. req=11 held, len=0 each
//     -> RR defined: grants alternate 01,10,01. Undefined: always 01.
//  5. rst_n pulsed low during word 2 of a 4-word burst
//     -> all outputs 0 immediately; after release, IDLE and a fresh grant only on a new req.
//  6. req=01 dropped after gnt, len=3
//     -> all 4 words still delivered; no new gnt until req is reasserted.

Source files
------------

// File: rtl/rom_burst_arbiter.sv
// -----------------------------------------------------------------------------
// rom_burst_arbiter
//
// Shares one combinational lookup ROM between NREQ requesters. A requester
// raises req with a start address and a burst length (words-1). When the block
// is idle it picks one winner, pulses that requester's gnt bit for one cycle,
// then walks the ROM from start_addr and streams each word out through a
// registered valid/ready port. Each word is tagged with the owner's index, and
// the final word of the burst is flagged.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration. The search starts
//                                    one past the last winner, or at index 0
//                                    after reset.
//                       undefined -> fixed priority. The lowest index wins and
//                                    no pointer register is built.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          per-requester request level (sampled only when idle)
//   start_addr   per-requester first word address, requester i at [i*AW +: AW]
//   burst_len    per-requester word count minus 1, requester i at [i*LW +: LW]
//   gnt          one-hot, one-cycle grant pulse
//   rom_addr     registered ROM address
//   rom_data     combinational ROM data for rom_addr
//   out_data     registered burst word
//   out_valid    out_data valid
//   out_ready    consumer accepts on out_valid && out_ready
//   out_id       index of the requester owning the current burst
//   out_last     marks the final word of a burst
//   busy         high whenever the block is not idle
// -----------------------------------------------------------------------------
module rom_burst_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 4,
  parameter int DW   = 8,
  parameter int LW   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] start_addr,
  input  logic [NREQ*LW-1:0] burst_len,
  output logic [NREQ-1:0]   gnt,
  output logic [AW-1:0]     rom_addr,
  input  logic [DW-1:0]     rom_data,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_id,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [AW-1:0]   r_rom_addr;
  logic [DW-1:0]   r_out_data;
  logic            r_out_valid;
  logic            r_out_last;
  logic [1:0]      r_out_id;
  logic [LW-1:0]   r_remain;

  logic [1:0]      w_winner;
  logic [NREQ-1:0] w_onehot;
  logic [AW-1:0]   w_start;
  logic [LW-1:0]   w_len;
  logic            w_load;

`ifdef ARB_ROUND_ROBIN_EN
  // Index where the next search begins: one past the most recent winner.
  logic [1:0]      r_rr_base;
  logic [1:0]      w_rr_next;
`endif

  // Winner selection. The first loop finds the lowest requesting index. In
  // round-robin mode the second loop overrides that with the lowest requesting
  // index at or above the search base, so the search wraps around naturally.
  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    w_winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) w_winner = 2'(i);
    end
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (2'(i) >= r_rr_base)) w_winner = 2'(i);
    end
`endif
  end

  // Route the winner's burst parameters and build its one-hot grant.
  always_comb begin
    w_start  = '0;
    w_len    = '0;
    w_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == 2'(i)) begin
        w_start     = start_addr[i*AW +: AW];
        w_len       = burst_len[i*LW +: LW];
        w_onehot[i] = 1'b1;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  assign w_rr_next = (w_winner == 2'(NREQ - 1)) ? 2'd0 : w_winner + 2'd1;
`endif

  // The output register can take a new word when it is empty or being drained.
  assign w_load = !r_out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_rom_addr  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_id    <= '0;
      r_remain    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr_base   <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments, so every branch
      // reads the pre-edge values no matter the statement order.
      r_gnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_gnt      <= w_onehot;
            r_out_id   <= w_winner;
            r_rom_addr <= w_start;
            r_remain   <= w_len;
            r_state    <= S_STREAM;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_base  <= w_rr_next;
`endif
          end
        end
        S_STREAM: begin
          if (w_load) begin
            r_out_data  <= rom_data;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_remain == '0);
            // Address is allowed to wrap modulo 2^AW.
            r_rom_addr  <= r_rom_addr + 1'b1;
            if (r_remain == '0) r_state  <= S_DRAIN;
            else                r_remain <= r_remain - 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rom_addr  = r_rom_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_id    = r_out_id;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_burst_arbiter
//
// The reference model works at burst level. When the block is idle and some
// requester is asking, the model picks a winner by the arbitration rule and
// queues every word of that burst up front. The output register then pops from
// this queue whenever it is empty or being drained. Once the queue is empty,
// the block drops busy on the handshake of the last word.
//
// The ROM is modelled as rom_data = {rom_addr, ~rom_addr}. A set of literal
// expectations pins the model on hand-worked bursts. These cover address wrap,
// backpressure, arbitration order, reset mid-burst, and req dropped after the
// grant.
// -----------------------------------------------------------------------------
module tb_rom_burst_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int LW   = 4;

  logic               clk        = 1'b0;
  logic               rst_n      = 1'b1;
  logic [NREQ-1:0]    req        = '0;
  logic [NREQ*AW-1:0] start_addr = '0;
  logic [NREQ*LW-1:0] burst_len  = '0;
  logic               out_ready  = 1'b1;

  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data;
  logic [DW-1:0]      out_data;
  logic               out_valid;
  logic [1:0]         out_id;
  logic               out_last;
  logic               busy;

  assign rom_data = {rom_addr, ~rom_addr};

  rom_burst_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .gnt        (gnt),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0] e_gnt;
  logic [AW-1:0]   e_addr;
  logic [DW-1:0]   e_data;
  logic            e_valid;
  logic            e_last;
  logic [1:0]      e_id;
  logic            e_busy;
  logic [DW:0]     m_q[$];   // {last, data} of words not yet loaded
`ifdef ARB_ROUND_ROBIN_EN
  int              m_rr;
`endif

  function automatic int pick(input logic [NREQ-1:0] r);
    int s;
`ifdef ARB_ROUND_ROBIN_EN
    s = m_rr;
`else
    s = 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (s + k) % NREQ;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic m_reset();
    e_gnt = '0; e_addr = '0; e_data = '0; e_valid = 1'b0;
    e_last = 1'b0; e_id = '0; e_busy = 1'b0;
    m_q.delete();
`ifdef ARB_ROUND_ROBIN_EN
    m_rr = 0;
`endif
  endtask

  task automatic m_step();
    int w;
    int n;
    logic [AW-1:0] s;
    logic [AW-1:0] a;
    logic [DW:0]   item;
    e_gnt = '0;
    if (!e_busy) begin
      if (req != '0) begin
        w = pick(req);
        s = start_addr[w*AW +: AW];
        n = int'(burst_len[w*LW +: LW]) + 1;
        e_gnt  = NREQ'(1) << w;
        e_id   = 2'(w);
        e_addr = s;
        m_q.delete();
        for (int k = 0; k < n; k++) begin
          a = s + AW'(k);
          m_q.push_back({(k == n - 1), a, ~a});
        end
        e_busy = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        m_rr = (w + 1) % NREQ;
`endif
      end
    end else if (!e_valid || out_ready) begin
      if (m_q.size() > 0) begin
        item    = m_q.pop_front();
        e_last  = item[DW];
        e_data  = item[DW-1:0];
        e_valid = 1'b1;
        e_addr  = e_addr + 1'b1;
      end else begin
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_busy  = 1'b0;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("gnt",       gnt,       e_gnt);
      check("rom_addr",  rom_addr,  e_addr);
      check("out_valid", out_valid, e_valid);
      check("out_data",  out_data,  e_data);
      check("out_last",  out_last,  e_last);
      check("out_id",    out_id,    e_id);
      check("busy",      busy,      e_busy);
    end
  end

  // Logs of accepted words {id, last, data} and of grant pulses.
  logic [10:0]     w_log[$];
  logic [NREQ-1:0] g_log[$];

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && out_valid && out_ready) w_log.push_back({out_id, out_last, out_data});
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (gnt != '0) g_log.push_back(gnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {busy, out_valid}, 2'b00);
  endtask

  task automatic expect_log(input string tag, input int n, input logic [1:0] id, input bit full,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0]  d[4];
    logic [10:0] want;
    logic [10:0] got;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    check({tag, "_count"}, w_log.size(), n);
    for (int k = 0; k < n; k++) begin
      want = {id, (full && k == n - 1), d[k]};
      got  = (k < w_log.size()) ? w_log[k] : 11'h7FF;
      check($sformatf("%s_w%0d", tag, k), got, want);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},       gnt,       0);
    check({tag, "_rom_addr"},  rom_addr,  0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_id"},    out_id,    0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_busy"},      busy,      0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0] g_exp[3];

  initial begin
    int n;
    int r;

    // Reset state.
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // 1: single requester, three words.
    @(negedge clk);
    w_log.delete();
    start_addr[0 +: AW] = 4'h2; burst_len[0 +: LW] = 4'd2; req = 2'b01; out_ready = 1'b1;
    @(negedge clk);
    check("t1_gnt", gnt, 2'b01);
    req = '0;
    @(negedge clk);
    check("t1_gnt_pulse", gnt, 2'b00);
    check("t1_first_valid", out_valid, 1'b1);
    wait_idle("t1", 50);
    expect_log("t1", 3, 2'd0, 1'b1, 8'h2D, 8'h3C, 8'h4B, 8'h00);

    // 2: requester 1 with address wrap.
    w_log.delete();
    start_addr[AW +: AW] = 4'hE; burst_len[LW +: LW] = 4'd3; req = 2'b10;
    @(negedge clk);
    check("t2_gnt", gnt, 2'b10);
    req = '0;
    wait_idle("t2", 50);
    expect_log("t2", 4, 2'd1, 1'b1, 8'hE1, 8'hF0, 8'h0F, 8'h1E);

    // 3: backpressure on the first word.
    w_log.delete();
    start_addr[0 +: AW] = 4'h5; burst_len[0 +: LW] = 4'd1; req = 2'b01; out_ready = 1'b0;
    @(negedge clk);
    check("t3_gnt", gnt, 2'b01);
    req = '0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t3_valid", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_hold_data%0d", i), out_data, 8'h5A);
      check($sformatf("t3_hold_addr%0d", i), rom_addr, 4'h6);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_idle("t3", 50);
    expect_log("t3", 2, 2'd0, 1'b1, 8'h5A, 8'h69, 8'h00, 8'h00);

    // 4: both requesting, single-word bursts, from a fresh reset.
    do_reset();
    g_log.delete();
    w_log.delete();
    start_addr[0 +: AW] = 4'h3; start_addr[AW +: AW] = 4'h9;
    burst_len = '0; req = 2'b11;
    n = 0;
    while (g_log.size() < 3 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    req = '0;
`ifdef ARB_ROUND_ROBIN_EN
    g_exp[0] = 2'b01; g_exp[1] = 2'b10; g_exp[2] = 2'b01;
`else
    g_exp[0] = 2'b01; g_exp[1] = 2'b01; g_exp[2] = 2'b01;
`endif
    check("t4_gnt_count", g_log.size(), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("t4_gnt%0d", k), (k < g_log.size()) ? g_log[k] : 2'b11, g_exp[k]);
    wait_idle("t4", 50);

    // 5: reset while the second word of a four-word burst is valid.
    @(negedge clk);
    w_log.delete();
    start_addr[0 +: AW] = 4'h0; burst_len[0 +: LW] = 4'd3; req = 2'b01; out_ready = 1'b1;
    @(negedge clk);
    check("t5_gnt", gnt, 2'b01);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check("t5_word2", out_data, 8'h1E);
    #1 rst_n = 1'b0;
    #1 check_all_zero("t5_rst");
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_post_busy", busy, 1'b0);
    check("t5_post_valid", out_valid, 1'b0);
    expect_log("t5a", 1, 2'd0, 1'b0, 8'h0F, 8'h00, 8'h00, 8'h00);
    w_log.delete();
    start_addr[0 +: AW] = 4'hC; burst_len[0 +: LW] = 4'd0; req = 2'b01;
    @(negedge clk);
    check("t5_regnt", gnt, 2'b01);
    req = '0;
    wait_idle("t5", 50);
    expect_log("t5b", 1, 2'd0, 1'b1, 8'hC3, 8'h00, 8'h00, 8'h00);

    // 6: req dropped right after the grant.
    w_log.delete();
    g_log.delete();
    start_addr[0 +: AW] = 4'h8; burst_len[0 +: LW] = 4'd3; req = 2'b01;
    @(negedge clk);
    check("t6_gnt", gnt, 2'b01);
    req = '0;
    start_addr[0 +: AW] = 4'h1;
    wait_idle("t6", 50);
    repeat (3) @(negedge clk);
    check("t6_gnt_count", g_log.size(), 1);
    expect_log("t6", 4, 2'd0, 1'b1, 8'h87, 8'h96, 8'hA5, 8'hB4);

    // Randomised traffic: requests, addresses, lengths and backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = $urandom_range(0, 9);
      req        = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
      start_addr = NREQ*AW'($urandom);
      burst_len  = NREQ*LW'($urandom);
      out_ready  = ($urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    req = '0;
    out_ready = 1'b1;
    wait_idle("rand", 100);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
